square_iter: RTL and testbench

- Iterative radix-2 shift-add squarer. Takes an unsigned W-bit value x and returns y = x*x, W*2 bits wide.
- Inverse companion of the square-root unit in the color_transform path. Converts a standard deviation back into a variance for the forward color-statistics match.
- Uses a start/busy/done handshake. A single adder handles one multiplier bit per clock.

---
 rtl/square_iter.sv | 147 ++++++++++++++
 tb/tb_square_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/square_iter.sv
// square_iter: iterative shift-add squarer, y = x*x.
//
// Squares the unsigned W-bit operand with a single adder. The default build
// consumes one multiplier bit per clock. Defining SQUARE_ITER_RADIX4_EN
// consumes two bits per clock instead and gives identical results in half the
// number of steps.
//
// Handshake: start is sampled only in IDLE or DONE, and x is captured on the
// same edge. busy is high while the unit is stepping. done pulses for exactly
// one cycle, and in that cycle y holds the new result. y keeps the result
// until the next completion. A start that is high during DONE begins the next
// operation with no idle cycle in between.
//
// Ports:
//   clk    in   1     rising-edge clock
//   reset  in   1     asynchronous, active-high reset
//   start  in   1     request strobe
//   x      in   W     unsigned operand
//   busy   out  1     high while stepping (RUN)
//   done   out  1     one-cycle completion pulse
//   y      out  2W    unsigned x*x, registered and held
//
// Parameter W: operand width. It must be even and at least 4.

module square_iter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   x,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] y
);

    localparam int CW = $clog2(W);

`ifdef SQUARE_ITER_RADIX4_EN
    localparam int            STEP = 2;
    localparam logic [CW-1:0] LAST = CW'(W/2 - 1);
`else
    localparam int            STEP = 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2*W-1:0]   add_term;
    logic [2*W-1:0]   acc_sum;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        y_d      = y_q;

        // Partial product selected by the low multiplier bit(s).
        add_term = '0;
`ifdef SQUARE_ITER_RADIX4_EN
        case (mplier_q[1:0])
            2'd1:    add_term = mcand_q;
            2'd2:    add_term = mcand_q << 1;
            2'd3:    add_term = mcand_q + (mcand_q << 1);
            default: add_term = '0;
        endcase
`else
        if (mplier_q[0]) begin
            add_term = mcand_q;
        end
`endif
        // This cannot overflow because (2^W-1)^2 < 2^(2W).
        acc_sum = acc_q + add_term;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, x};
                    mplier_d = x;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q + 1'b1;
                // The final step publishes its own addition directly.
                if (cnt_q == LAST) begin
                    y_d     = acc_sum;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered and decoded from the next state.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_square_iter.sv
// Testbench for square_iter. The reference model is plain multiplication.
// Cycle 0 is the cycle in which start is high. Inputs are driven at the
// negative edge, and outputs are sampled at the negative edge before new
// inputs are driven.

module tb_square_iter;

    localparam int W = 16;
`ifdef SQUARE_ITER_RADIX4_EN
    localparam int LAT   = W/2 + 1;
    localparam int NRAND = 1000;
`else
    localparam int LAT   = W + 1;
    localparam int NRAND = 300;
`endif

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   x;
    logic           busy;
    logic           done;
    logic [2*W-1:0] y;

    int n_checks;
    int n_fail;
    logic [63:0] model_y;  // value y must be showing now

    square_iter #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sq(input logic [W-1:0] v);
        logic [63:0] a;
        a = 64'(v);
        return a * a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one operation. If pre_started is set, start/x were already driven
    // in the previous DONE cycle. glitch_c > 0 pulses start with glitch_x in
    // that cycle. If chain is set, start is held with nxt during DONE.
    task automatic run_op(input logic [W-1:0] val, input bit pre_started,
                          input int glitch_c, input logic [W-1:0] glitch_x,
                          input bit chain, input logic [W-1:0] nxt);
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
            x     = val;
        end
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c == LAT) model_y = sq(val);
            check("busy", 64'(busy), 64'(c < LAT));
            check("done", 64'(done), 64'(c == LAT));
            check("y", 64'(y), model_y);
            start = 1'b0;
            x     = W'($urandom);  // x must be ignored after acceptance
            if (c == glitch_c) begin
                start = 1'b1;
                x     = glitch_x;
            end
            if (c == LAT && chain) begin
                start = 1'b1;
                x     = nxt;
            end
        end
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_done", 64'(done), 64'd0);
            check("idle_y", 64'(y), model_y);
        end
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] nv;
        int gap;
        bit pre;

        n_checks = 0;
        n_fail   = 0;
        model_y  = 64'd0;
        reset    = 1'b1;
        start    = 1'b0;
        x        = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        reset = 1'b0;

        // x=0: full-length run with result 0.
        run_op('0, 1'b0, 0, '0, 1'b0, '0);
        idle_hold(3);

        // Edge values, each followed by 20 idle cycles with y held.
        run_op(16'd1, 1'b0, 0, '0, 1'b0, '0);
        idle_hold(20);
        run_op(16'd255, 1'b0, 0, '0, 1'b0, '0);
        check("y_255", 64'(y), 64'd65025);
        idle_hold(20);
        run_op(16'hFFFF, 1'b0, 0, '0, 1'b0, '0);
        check("y_ffff", 64'(y), 64'hFFFE0001);
        idle_hold(20);

        // A start pulse while busy is ignored.
        run_op(16'd3, 1'b0, 5, 16'd1000, 1'b0, '0);
        check("y_9", 64'(y), 64'd9);
        idle_hold(3);

        // Back-to-back: start is held during DONE, so busy never drops.
        run_op(16'd12, 1'b0, 0, '0, 1'b1, 16'd40000);
        run_op(16'd40000, 1'b1, 0, '0, 1'b0, '0);
        check("y_b2b", 64'(y), 64'd1600000000);
        idle_hold(2);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1;
        x     = 16'd500;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);  // cycle 8
        reset = 1'b1;
        #1;
        model_y = 64'd0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_y", 64'(y), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_hold(LAT + 2);  // the aborted operation must not complete
        run_op(16'd7, 1'b0, 0, '0, 1'b0, '0);
        check("y_49", 64'(y), 64'd49);
        idle_hold(2);

        // Random sweep with random gaps. A gap of 0 chains the next operation.
        pre = 1'b0;
        v   = W'($urandom);
        for (int i = 0; i < NRAND; i++) begin
            gap = $urandom_range(0, 2);
            nv  = W'($urandom);
            if ((i % 10) == 0) nv = W'($urandom_range(0, 3));
            if (i == NRAND - 1) gap = 1;
            run_op(v, pre, 0, '0, (gap == 0), nv);
            if (gap != 0) idle_hold(gap - 1);
            pre = (gap == 0);
            v   = nv;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
